hamdec_9_5: RTL and testbench

// - Registered single-error-correcting Hamming(9,5) decoder: 9-bit codeword in, corrected 5-bit information out.
// - Computes a 4-bit even-parity syndrome, flips the addressed bit, extracts data and flags correctable/uncorrectable errors.
// - Sits on the receive path after the channel, ahead of the finger-count/display converter logic.

---
 rtl/hamdec_9_5.sv | 87 ++++++++
 tb/tb_hamdec_9_5.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hamdec_9_5.sv
// Registered single-error-correcting Hamming(9,5) decoder with one cycle of latency.
// Optional saturating corrected-error counter enabled by defining HAMDEC_ERR_CNT_EN.
module hamdec_9_5 #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [8:0]       cw,
   output logic             out_valid,
   output logic [4:0]       hs,
   output logic [3:0]       syndrome,
   output logic             err_corr,
   output logic             err_unc
`ifdef HAMDEC_ERR_CNT_EN
   ,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   localparam int unsigned CW_W   = 9;
   localparam int unsigned INFO_W = 5;
   localparam int unsigned SYN_W  = 4;

   if (CNT_W == 0) begin : g_cnt_w_chk
      $error("hamdec_9_5: CNT_W must be at least 1");
   end

   logic [SYN_W-1:0]  syn_c;
   logic [CW_W-1:0]   flip_c;
   logic [CW_W-1:0]   fixed_c;
   logic [INFO_W-1:0] hs_c;
   logic              corr_c;
   logic              unc_c;

   // Syndrome bits: each checks the positions whose index has that bit set.
   always_comb begin
      syn_c    = '0;
      syn_c[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6] ^ cw[8];
      syn_c[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
      syn_c[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
      syn_c[3] = cw[7] ^ cw[8];
   end

   // Syndromes 10..15 address no real position, so no bit is flipped for them.
   always_comb begin
      flip_c = '0;
      for (int i = 0; i < int'(CW_W); i++) begin
         flip_c[i] = (syn_c == SYN_W'(i + 1));
      end
      fixed_c = cw ^ flip_c;
      corr_c  = (syn_c != '0) && (syn_c <= SYN_W'(CW_W));
      unc_c   = (syn_c > SYN_W'(CW_W));
      hs_c    = {fixed_c[8], fixed_c[6], fixed_c[5], fixed_c[4], fixed_c[2]};
   end

   // Output register: results only advance on accepted words, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         hs        <= '0;
         syndrome  <= '0;
         err_corr  <= 1'b0;
         err_unc   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            hs       <= hs_c;
            syndrome <= syn_c;
            err_corr <= corr_c;
            err_unc  <= unc_c;
         end
      end
   end

`ifdef HAMDEC_ERR_CNT_EN
   // Corrected-error counter, saturating at all ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (in_valid && corr_c && (err_cnt != {CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_hamdec_9_5.sv
// Bench for hamdec_9_5: XOR-of-positions decode model checked every cycle plus literal vectors.
// Counter checks (including a CNT_W=4 instance) are active when HAMDEC_ERR_CNT_EN is defined.
module tb_hamdec_9_5;

   typedef struct packed {
      logic [4:0] hs;
      logic [3:0] syn;
      logic       corr;
      logic       unc;
   } dec_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [8:0] cw;
   logic       out_valid;
   logic [4:0] hs;
   logic [3:0] syndrome;
   logic       err_corr;
   logic       err_unc;

   int checks;
   int errors;
   bit chk_en;

   logic m_valid;
   dec_t m_dec;
   int   m_cnt;
   int   m_cnt_s;

`ifdef HAMDEC_ERR_CNT_EN
   logic [15:0] err_cnt;
   logic [3:0]  err_cnt_s;
   logic        s_valid;
   logic [4:0]  s_hs;
   logic [3:0]  s_syn;
   logic        s_corr;
   logic        s_unc;
`endif

   hamdec_9_5 u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .cw        (cw),
      .out_valid (out_valid),
      .hs        (hs),
      .syndrome  (syndrome),
      .err_corr  (err_corr),
      .err_unc   (err_unc)
`ifdef HAMDEC_ERR_CNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

`ifdef HAMDEC_ERR_CNT_EN
   hamdec_9_5 #(.CNT_W(4)) u_small (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .cw        (cw),
      .out_valid (s_valid),
      .hs        (s_hs),
      .syndrome  (s_syn),
      .err_corr  (s_corr),
      .err_unc   (s_unc),
      .err_cnt   (err_cnt_s)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Syndrome of a Hamming code is the XOR of the indices of all set positions.
   function automatic dec_t model_dec(input logic [8:0] w);
      dec_t       d;
      int         s;
      logic [8:0] f;
      s = 0;
      for (int i = 1; i <= 9; i++) if (w[i-1]) s = s ^ i;
      f = w;
      if (s >= 1 && s <= 9) f[s-1] = ~f[s-1];
      d.syn  = 4'(s);
      d.corr = (s >= 1 && s <= 9);
      d.unc  = (s >= 10);
      d.hs   = {f[8], f[6], f[5], f[4], f[2]};
      return d;
   endfunction

   function automatic logic [8:0] encode(input logic [4:0] info, input int errpos);
      logic [8:0] w;
      int         s;
      w    = '0;
      w[2] = info[0];
      w[4] = info[1];
      w[5] = info[2];
      w[6] = info[3];
      w[8] = info[4];
      s = 0;
      for (int i = 1; i <= 9; i++) if (w[i-1]) s = s ^ i;
      w[0] = s[0];
      w[1] = s[1];
      w[3] = s[2];
      w[7] = s[3];
      if (errpos >= 1 && errpos <= 9) w[errpos-1] = ~w[errpos-1];
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference pipeline: one-cycle latency, holds on idle, reset clears.
   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_dec   <= '0;
         m_cnt   <= 0;
         m_cnt_s <= 0;
      end else begin
         m_valid <= in_valid;
         if (in_valid) begin
            m_dec <= model_dec(cw);
            if (model_dec(cw).corr) begin
               if (m_cnt < 65535) m_cnt <= m_cnt + 1;
               if (m_cnt_s < 15) m_cnt_s <= m_cnt_s + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
         chk("cyc_hs", 32'(hs), 32'(m_dec.hs));
         chk("cyc_syndrome", 32'(syndrome), 32'(m_dec.syn));
         chk("cyc_err_corr", 32'(err_corr), 32'(m_dec.corr));
         chk("cyc_err_unc", 32'(err_unc), 32'(m_dec.unc));
`ifdef HAMDEC_ERR_CNT_EN
         chk("cyc_err_cnt", 32'(err_cnt), 32'(m_cnt));
         chk("cyc_err_cnt_small", 32'(err_cnt_s), 32'(m_cnt_s));
         chk("cyc_small_hs", 32'(s_hs), 32'(m_dec.hs));
`endif
      end
   end

   task automatic send_check(input logic [8:0] w, input logic [4:0] e_hs, input logic [3:0] e_syn,
                             input logic e_corr, input logic e_unc);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      cw       = w;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("lit_out_valid", 32'(out_valid), 32'd1);
      chk("lit_hs", 32'(hs), 32'(e_hs));
      chk("lit_syndrome", 32'(syndrome), 32'(e_syn));
      chk("lit_err_corr", 32'(err_corr), 32'(e_corr));
      chk("lit_err_unc", 32'(err_unc), 32'(e_unc));
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      chk_en   = 1'b0;
      rst      = 1'b1;
      in_valid = 1'b0;
      cw       = '0;
      @(posedge clk);
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_hs", 32'(hs), 32'd0);
      chk("rst_syndrome", 32'(syndrome), 32'd0);
      chk("rst_flags", 32'({err_corr, err_unc}), 32'd0);
`ifdef HAMDEC_ERR_CNT_EN
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
      rst = 1'b0;

      send_check(9'b000001000, 5'b00000, 4'd4, 1'b1, 1'b0);
      send_check(9'b001000111, 5'b00001, 4'd7, 1'b1, 1'b0);
      send_check(9'b100011001, 5'b00010, 4'd9, 1'b1, 1'b0);
      send_check(9'b000000111, 5'b00001, 4'd0, 1'b0, 1'b0);
      send_check(9'b101111110, 5'b11111, 4'd8, 1'b1, 1'b0);
      send_check(9'b010000010, 5'b00000, 4'd10, 1'b0, 1'b1);

      // Idle cycle: valid drops, last result held.
      @(posedge clk);
      #1;
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_syndrome_hold", 32'(syndrome), 32'd10);
      chk("idle_unc_hold", 32'(err_unc), 32'd1);

      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 32 words back to back, one single-bit error each.
      for (int i = 0; i < 32; i++) begin
         @(posedge clk);
         #1;
         if (i > 0) begin
            chk("b2b_valid", 32'(out_valid), 32'd1);
            chk("b2b_hs", 32'(hs), 32'(i - 1));
         end
         in_valid = 1'b1;
         cw       = encode(5'(i), (i % 9) + 1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("b2b_valid_last", 32'(out_valid), 32'd1);
      chk("b2b_hs_last", 32'(hs), 32'd31);
`ifdef HAMDEC_ERR_CNT_EN
      chk("b2b_err_cnt", 32'(err_cnt), 32'd32);
      chk("b2b_err_cnt_sat", 32'(err_cnt_s), 32'd15);
`endif

      // Reset wins over a valid word on the same edge.
      @(posedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b1;
      cw       = 9'b001000111;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("rstv_out_valid", 32'(out_valid), 32'd0);
      chk("rstv_hs", 32'(hs), 32'd0);
      chk("rstv_syndrome", 32'(syndrome), 32'd0);
      chk("rstv_flags", 32'({err_corr, err_unc}), 32'd0);
`ifdef HAMDEC_ERR_CNT_EN
      chk("rstv_err_cnt", 32'(err_cnt), 32'd0);
`endif
      @(posedge clk);
      #1;
      chk("rstv_no_late_valid", 32'(out_valid), 32'd0);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
